uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
- Round-robin arbiter that shares the 8-bit bidirectional uio pad bus of tt_um_lditsche among NUM_REQ internal requesters.
- Owns uio_out/uio_oe, enforces a turnaround gap with all pads released between owners, caps burst length, and returns sampled pad data to whichever requester is reading.
- Sits between the internal engines and the top-level uio_in/uio_out/uio_oe pins.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MAX_BURST, 8, maximum consecutive OWN cycles per grant (1..255)
- TURNAROUND, 1, cycles with uio_oe=0 between successive grants (1..4)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester bus request; level, held until granted
- done  in  NUM_REQ  per-requester release strobe; only the owner's bit is used
- dir  in  NUM_REQ  per-requester direction: 1=drive pads, 0=sample pads
- wdata  in  8*NUM_REQ  per-requester drive data; slice i = wdata[8i+7:8i]
- uio_in  in  8  pad input path
- uio_out  out  8  pad output path
- uio_oe  out  8  pad enable (1=output)
- gnt  out  NUM_REQ  one-hot grant, registered
- owner  out  $clog2(NUM_REQ)  index of current owner; valid while busy=1
- busy  out  1  high in OWN
- rdata  out  8  registered sample of uio_in
- rvalid  out  1  rdata valid strobe

Behaviour:
- Reset values: gnt=0, owner=0, busy=0, uio_oe=0, uio_out=0, rdata=0, rvalid=0, state=IDLE, burst_cnt=0, last_owner=NUM_REQ-1 (so requester 0 wins first). Asserting rst releases the pads immediately, with no clock edge.
- FSM states: IDLE, OWN, TURN.
- IDLE:
  - Each edge, arbitrate over req. The search starts at (last_owner+1) mod NUM_REQ and takes the first set bit.
  - On a winner: go to OWN, gnt=onehot(winner), owner=winner, last_owner=winner, burst_cnt=0.
  - Latency: req sampled high at edge N gives gnt high after edge N.
- OWN:
  - busy=1.
  - uio_oe=8'hFF when dir[owner]=1, else 8'h00. uio_out=wdata slice[owner] when dir[owner]=1, else 0. Both are combinational from owner/state.
  - When dir[owner]=0, each edge registers rdata<=uio_in and pulses rvalid for one cycle. Data is therefore 1 cycle behind the pads.
  - burst_cnt increments each edge.
  - Release occurs when done[owner]=1, or req[owner]=0, or burst_cnt==MAX_BURST-1. On release the next state is TURN with tcnt=0, and gnt is cleared on the same edge.
  - A done pulse on a non-owner bit is ignored.
- TURN:
  - uio_oe=0, uio_out=0, gnt=0, busy=0, rvalid=0.
  - tcnt increments each edge. When tcnt==TURNAROUND-1, arbitrate exactly as in IDLE: a winner goes straight to OWN, otherwise go to IDLE.
- Simultaneous events:
  - Owner raises done on the same cycle another requester raises req: release first, then the turnaround gap, then round-robin picks the next index after the old owner.
  - Owner keeps req high after a forced release: it is re-granted only if no other index between it and itself in round-robin order is requesting.
- Fairness bound: with all requesters asserting, any requester waits at most (NUM_REQ-1)*(MAX_BURST+TURNAROUND) cycles.
- MAX_BURST=1: every grant is one cycle, followed by TURNAROUND.
- dir change mid-grant: takes effect combinationally on uio_oe the same cycle. Requesters must not do this; it is not checked.
- Width rules: burst_cnt is 8 bits; owner and last_owner are $clog2(NUM_REQ) bits; the round-robin index wraps modulo NUM_REQ. For non-power-of-2 NUM_REQ, out-of-range indices are never selected.

Decomposition:
- Shared package uio_arb_pkg holds: state enum (IDLE, OWN, TURN), PAD_W=8, and a function clog2-safe OWNER_W.
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs req[NUM_REQ] and start index; outputs valid and index. It is reusable by other arbiters in the design.

Test Plan:
- Reset and first grant: assert rst mid-OWN with dir=1 -> uio_oe drops to 0 before the next clk. Release rst, req=4'b0001 -> gnt=0001 one edge later, uio_oe=8'hFF, uio_out=wdata[7:0]=8'hA5.
- Burst cap: req=0001 held, done=0, MAX_BURST=8 -> busy high exactly 8 cycles, then 1 cycle with uio_oe=0, then gnt=0001 again (sole requester).
- Round robin: req=4'b1111 held -> grant order 0,1,2,3,0; each grant lasts 8 cycles with a 1-cycle gap; no index is repeated before all others have been served.
- Early release and simultaneous request: owner 2 pulses done on cycle 3 of its grant while req[3] rises the same cycle -> gnt=0 for 1 cycle, then gnt=1000.
- Read path: owner 1 with dir=0, uio_in=8'h3C then 8'hC3 -> uio_oe=0, rdata=3C then C3 with rvalid=1 one cycle behind the pads; rvalid=0 in TURN.
- Drop request: owner 0 deasserts req on cycle 2 -> released same edge, TURN, then IDLE with gnt=0 and uio_oe=0 held.

Source files
------------

// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad-bus arbiter and its round-robin picker.
package uio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    localparam int PAD_W = 8;

    // Index width that stays at least one bit wide even for a single requester.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the start index, wrapping modulo N.
module rr_pick
    import uio_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic          valid,
    output logic [IW-1:0] index
);

    always_comb begin
        int s;
        int k;
        valid = 1'b0;
        index = '0;
        s     = (int'(start) < N) ? int'(start) : 0;
        k     = 0;
        // Walk from the farthest offset back to the start so the nearest request is written last.
        for (int i = N - 1; i >= 0; i--) begin
            k = (s + i) % N;
            if (req[k]) begin
                valid = 1'b1;
                index = IW'(k);
            end
        end
    end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Round-robin owner of the shared uio pad bus: burst capping, released-pad turnaround
// between owners, and a registered read-back path for sampling owners.
module uio_bus_arbiter
    import uio_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8,
    parameter int TURNAROUND = 1,
    localparam int OW        = owner_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    // Handshake: req is a level held until gnt returns; the owner keeps the bus while its
    // req stays high, done stays low and the burst cap is not reached. done is a one-cycle
    // release strobe honoured only on the owner's bit. gnt drops on the releasing edge.
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       done,
    input  logic [NUM_REQ-1:0]       dir,
    input  logic [PAD_W*NUM_REQ-1:0] wdata,
    input  logic [PAD_W-1:0]         uio_in,
    output logic [PAD_W-1:0]         uio_out,
    output logic [PAD_W-1:0]         uio_oe,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [OW-1:0]            owner,
    output logic                     busy,
    output logic [PAD_W-1:0]         rdata,
    output logic                     rvalid,
    output state_t                   fsm_state
);

    state_t             state;
    state_t             next_state;
    logic [OW-1:0]      owner_q;
    logic [OW-1:0]      last_owner;
    logic [OW-1:0]      start_idx;
    logic [OW-1:0]      pick_idx;
    logic               pick_valid;
    logic [7:0]         burst_cnt;
    logic [2:0]         tcnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic               release_own;
    logic               turn_end;
    logic               arb_now;
    logic               take;
    logic               drive_pads;

    assign start_idx = (last_owner == OW'(NUM_REQ - 1)) ? '0 : last_owner + OW'(1);

    rr_pick #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_pick (
        .req   (req),
        .start (start_idx),
        .valid (pick_valid),
        .index (pick_idx)
    );

    always_comb begin
        release_own = done[owner_q] | ~req[owner_q] | (burst_cnt == 8'(MAX_BURST - 1));
        turn_end    = (tcnt == 3'(TURNAROUND - 1));
        arb_now     = (state == IDLE) || ((state == TURN) && turn_end);
        take        = arb_now && pick_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pick_valid) next_state = OWN;
            end
            OWN: begin
                if (release_own) next_state = TURN;
            end
            TURN: begin
                if (turn_end) next_state = pick_valid ? OWN : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Pads follow state directly, so an asynchronous reset releases them without a clock edge.
    always_comb begin
        busy       = (state == OWN);
        drive_pads = busy && dir[owner_q];
        uio_oe     = drive_pads ? {PAD_W{1'b1}} : '0;
        uio_out    = drive_pads ? wdata[int'(owner_q)*PAD_W +: PAD_W] : '0;
        gnt        = gnt_q;
        owner      = owner_q;
        fsm_state  = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q    <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            burst_cnt  <= '0;
            tcnt       <= '0;
            gnt_q      <= '0;
            rdata      <= '0;
            rvalid     <= 1'b0;
        end else begin
            rvalid <= 1'b0;
            if (take) begin
                owner_q    <= pick_idx;
                last_owner <= pick_idx;
                burst_cnt  <= '0;
                gnt_q      <= NUM_REQ'(1) << pick_idx;
            end else if (state == OWN) begin
                burst_cnt <= burst_cnt + 8'd1;
                if (release_own) gnt_q <= '0;
            end

            if (state == OWN) begin
                tcnt <= '0;
            end else if (state == TURN) begin
                tcnt <= tcnt + 3'd1;
            end

            // The sample on the releasing edge is dropped so rvalid never appears in TURN.
            if ((state == OWN) && !dir[owner_q] && !release_own) begin
                rdata  <= uio_in;
                rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Self-checking bench for uio_bus_arbiter: vector table, directed corner sequences, random run vs. reference model.
module tb_uio_bus_arbiter;
    import uio_arb_pkg::*;

    localparam int N  = 4;
    localparam int MB = 8;
    localparam int TA = 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req, done, dir;
    logic [8*N-1:0]  wdata;
    logic [7:0]      uio_in, uio_out, uio_oe, rdata;
    logic [N-1:0]    gnt;
    logic [1:0]      owner;
    logic            busy, rvalid;
    state_t          fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    // Reference model: who holds the bus, for how long, and how much gap remains.
    int m_owner, m_age, m_gap, m_last;
    int cnt, w, len;
    int exp_order[5] = '{0, 1, 2, 3, 0};

    typedef struct {
        logic [N-1:0] req, done, dir;
        logic [7:0]   uin;
        logic [N-1:0] gnt;
        logic         busy;
        logic [1:0]   own;
        logic [7:0]   oe, out;
        logic         rv;
        logic [7:0]   rd;
    } vec_t;
    vec_t vt[12];

    uio_bus_arbiter #(
        .NUM_REQ    (N),
        .MAX_BURST  (MB),
        .TURNAROUND (TA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .dir       (dir),
        .wdata     (wdata),
        .uio_in    (uio_in),
        .uio_out   (uio_out),
        .uio_oe    (uio_oe),
        .gnt       (gnt),
        .owner     (owner),
        .busy      (busy),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N-1:0] di,
                         input logic [7:0] ui);
        req = r;
        done = d;
        dir = di;
        uio_in = ui;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive('0, '0, '0, 8'h00);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_age   = 0;
        m_gap   = 0;
        m_last  = N - 1;
        exp_q.delete();
    endtask

    task automatic model_check();
        logic       e_busy;
        logic       e_drv;
        logic [7:0] e_rd;
        e_busy = (m_owner >= 0);
        e_drv  = 1'b0;
        if (e_busy) e_drv = dir[m_owner];
        check("rnd_busy", busy, e_busy);
        if (e_busy) begin
            check("rnd_gnt", gnt, 32'(1) << m_owner);
            check("rnd_owner", owner, m_owner);
        end else begin
            check("rnd_gnt", gnt, 0);
        end
        if (e_drv) begin
            check("rnd_oe", uio_oe, 8'hFF);
            check("rnd_out", uio_out, wdata[8*m_owner +: 8]);
        end else begin
            check("rnd_oe", uio_oe, 8'h00);
            check("rnd_out", uio_out, 8'h00);
        end
        check("rnd_rvalid", rvalid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
            e_rd = exp_q.pop_front();
            check("rnd_rdata", rdata, e_rd);
        end
    endtask

    // Advance the model across one clock edge using the inputs applied this cycle.
    task automatic model_step();
        bit rel;
        int idx;
        if (m_owner >= 0) begin
            rel = done[m_owner] || !req[m_owner] || (m_age + 1 == MB);
            if (!dir[m_owner] && !rel) exp_q.push_back(uio_in);
            if (rel) begin
                m_owner = -1;
                m_gap   = TA;
            end else begin
                m_age++;
            end
        end else begin
            if (m_gap > 0) m_gap--;
            if (m_gap == 0) begin
                for (int k = 1; k <= N; k++) begin
                    idx = (m_last + k) % N;
                    if (req[idx] && m_owner < 0) begin
                        m_owner = idx;
                        m_last  = idx;
                        m_age   = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        wdata = 32'h3CC35AA5;
        drive('0, '0, '0, 8'h00);

        vt[0]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[1]  = '{4'b0001, 4'b0000, 4'b0001, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[2]  = '{4'b0001, 4'b0000, 4'b0001, 8'h00, 4'b0001, 1'b1, 2'd0, 8'hFF, 8'hA5, 1'b0, 8'h00};
        vt[3]  = '{4'b0001, 4'b0001, 4'b0001, 8'h00, 4'b0001, 1'b1, 2'd0, 8'hFF, 8'hA5, 1'b0, 8'h00};
        vt[4]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[5]  = '{4'b0100, 4'b0000, 4'b0000, 8'h3C, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[6]  = '{4'b0100, 4'b0000, 4'b0000, 8'h77, 4'b0100, 1'b1, 2'd2, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[7]  = '{4'b0100, 4'b0001, 4'b0000, 8'h88, 4'b0100, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1, 8'h77};
        vt[8]  = '{4'b0000, 4'b0000, 4'b0000, 8'h99, 4'b0100, 1'b1, 2'd2, 8'h00, 8'h00, 1'b1, 8'h88};
        vt[9]  = '{4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[10] = '{4'b1010, 4'b0000, 4'b1000, 8'h00, 4'b0000, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0, 8'h00};
        vt[11] = '{4'b1010, 4'b0000, 4'b1000, 8'h00, 4'b1000, 1'b1, 2'd3, 8'hFF, 8'h3C, 1'b0, 8'h00};

        do_reset();
        check("rst_gnt", gnt, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        check("rst_oe", uio_oe, 0);
        check("rst_out", uio_out, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_state", fsm_state, IDLE);

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].req, vt[i].done, vt[i].dir, vt[i].uin);
            #3;
            check($sformatf("vec%0d_gnt", i), gnt, vt[i].gnt);
            check($sformatf("vec%0d_busy", i), busy, vt[i].busy);
            check($sformatf("vec%0d_oe", i), uio_oe, vt[i].oe);
            check($sformatf("vec%0d_out", i), uio_out, vt[i].out);
            check($sformatf("vec%0d_rvalid", i), rvalid, vt[i].rv);
            if (vt[i].busy) check($sformatf("vec%0d_owner", i), owner, vt[i].own);
            if (vt[i].rv) check($sformatf("vec%0d_rdata", i), rdata, vt[i].rd);
            tick();
        end

        // Asynchronous reset mid-grant must release the pads before any clock edge.
        #3;
        check("pre_rst_oe", uio_oe, 8'hFF);
        rst = 1'b1;
        #1;
        check("async_rst_oe", uio_oe, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_gnt", gnt, 0);
        drive(4'b0001, 4'b0000, 4'b0001, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        check("first_grant_wait", gnt, 0);
        tick();
        check("first_grant_gnt", gnt, 4'b0001);
        check("first_grant_oe", uio_oe, 8'hFF);
        check("first_grant_out", uio_out, 8'hA5);

        // Burst cap with a sole requester.
        cnt = 0;
        while (busy === 1'b1 && cnt < 50) begin
            cnt++;
            tick();
        end
        check("burst_len", cnt, MB);
        check("burst_gap_oe", uio_oe, 0);
        check("burst_gap_busy", busy, 0);
        tick();
        check("burst_regrant", gnt, 4'b0001);

        // Round robin with everyone requesting.
        do_reset();
        drive(4'b1111, 4'b0000, 4'b1111, 8'h00);
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (busy !== 1'b1 && w < 20) begin
                tick();
                w++;
            end
            if (g > 0) check($sformatf("rr%0d_gap", g), w, TA);
            check($sformatf("rr%0d_owner", g), owner, exp_order[g]);
            check($sformatf("rr%0d_gnt", g), gnt, 32'(1) << exp_order[g]);
            len = 0;
            while (busy === 1'b1 && len < 50) begin
                len++;
                tick();
            end
            check($sformatf("rr%0d_len", g), len, MB);
        end

        // Early release by owner 2 while requester 3 raises req on the same cycle.
        do_reset();
        drive(4'b0100, 4'b0000, 4'b0000, 8'h00);
        tick();
        check("early_gnt", gnt, 4'b0100);
        tick();
        tick();
        drive(4'b1100, 4'b0100, 4'b0000, 8'h00);
        tick();
        drive(4'b1000, 4'b0000, 4'b0000, 8'h00);
        check("early_gap_gnt", gnt, 0);
        check("early_gap_busy", busy, 0);
        tick();
        check("early_next_gnt", gnt, 4'b1000);
        check("early_next_owner", owner, 3);

        // Owner drops req on its second cycle: TURN, then IDLE with the pads held released.
        do_reset();
        drive(4'b0001, 4'b0000, 4'b0001, 8'h00);
        tick();
        tick();
        drive(4'b0000, 4'b0000, 4'b0001, 8'h00);
        tick();
        check("drop_turn_state", fsm_state, TURN);
        check("drop_turn_oe", uio_oe, 0);
        tick();
        check("drop_idle_state", fsm_state, IDLE);
        check("drop_idle_gnt", gnt, 0);
        tick();
        check("drop_idle_oe", uio_oe, 0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                done[i] = ($urandom_range(0, 9) == 0);
                if ($urandom_range(0, 7) == 0) dir[i] = ~dir[i];
            end
            uio_in = 8'($urandom_range(0, 255));
            wdata  = $urandom;
            #3;
            model_check();
            model_step();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
